// File: rtl/plic_mctx_core.sv
// Multi-context PLIC core: per-source gateways with level or counted-edge
// triggering, per-context enable/threshold arbitration and claim/complete.
module plic_mctx_core #(
    parameter int IRQ_NUM    = 32,
    parameter int CTX_NUM    = 2,
    parameter int PRIO_WIDTH = 3,
    parameter int EDGE_CNT_W = 3,
    localparam int ID_W      = $clog2(IRQ_NUM)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [IRQ_NUM-1:0]             irq_i,
    input  logic [IRQ_NUM-1:0]             tm_i,
    input  logic [IRQ_NUM*PRIO_WIDTH-1:0]  prio_i,
    input  logic [CTX_NUM*IRQ_NUM-1:0]     ie_i,
    input  logic [CTX_NUM*PRIO_WIDTH-1:0]  thold_i,
    input  logic [CTX_NUM-1:0]             claim_i,
    input  logic [CTX_NUM-1:0]             comp_i,
    input  logic [CTX_NUM*ID_W-1:0]        comp_id_i,
    output logic [IRQ_NUM-1:0]             ip_o,
    output logic [CTX_NUM*ID_W-1:0]        id_o,
    output logic [CTX_NUM*ID_W-1:0]        claim_id_o,
    output logic [CTX_NUM-1:0]             irq_o
);

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PEND,
        GW_SERV
    } gw_e;

    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

    logic [IRQ_NUM-1:0][PRIO_WIDTH-1:0] prio;
    logic [CTX_NUM-1:0][IRQ_NUM-1:0]    ie;
    logic [CTX_NUM-1:0][PRIO_WIDTH-1:0] thold;
    logic [CTX_NUM-1:0][ID_W-1:0]       comp_id;
    logic [CTX_NUM-1:0][ID_W-1:0]       claim_id;
    logic [CTX_NUM-1:0][ID_W-1:0]       id_q;
    logic [CTX_NUM-1:0][ID_W-1:0]       id_d;
    logic [CTX_NUM-1:0][ID_W-1:0]       best_id;
    logic [CTX_NUM-1:0][PRIO_WIDTH-1:0] best_prio;
    logic [CTX_NUM-1:0]                 irq_q;

    logic [IRQ_NUM-1:0] sync1_q;
    logic [IRQ_NUM-1:0] sync2_q;
    logic [IRQ_NUM-1:0] sync3_q;
    logic [IRQ_NUM-1:0] rise;
    logic [IRQ_NUM-1:0] grant;
    logic [IRQ_NUM-1:0] comp_ok;
    logic [IRQ_NUM-1:0] pend_d;
    logic [IRQ_NUM-1:0] ip_q;

    gw_e st_q [IRQ_NUM];
    gw_e st_d [IRQ_NUM];
    logic [IRQ_NUM-1:0][EDGE_CNT_W-1:0] cnt_q;
    logic [IRQ_NUM-1:0][EDGE_CNT_W-1:0] cnt_d;

    assign prio    = prio_i;
    assign ie      = ie_i;
    assign thold   = thold_i;
    assign comp_id = comp_id_i;
    assign rise    = sync2_q & ~sync3_q;

    // Lower-index contexts win when several claim the same id.
    always_comb begin
        claim_id = '0;
        if (!rst_i) begin
            for (int c = 0; c < CTX_NUM; c++) begin
                claim_id[c] = id_q[c];
                for (int d = 0; d < c; d++) begin
                    if (claim_i[d] && id_q[d] == id_q[c]) begin
                        claim_id[c] = '0;
                    end
                end
            end
        end
    end

    always_comb begin
        grant   = '0;
        comp_ok = '0;
        for (int c = 0; c < CTX_NUM; c++) begin
            if (claim_i[c] && claim_id[c] != '0
                && int'(claim_id[c]) < IRQ_NUM) begin
                grant[claim_id[c]] = 1'b1;
            end
            if (comp_i[c] && comp_id[c] != '0
                && int'(comp_id[c]) < IRQ_NUM
                && ie[c][comp_id[c]]) begin
                comp_ok[comp_id[c]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < IRQ_NUM; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            unique case (st_q[i])
                GW_IDLE: begin
                    if (tm_i[i] ? rise[i] : sync2_q[i]) begin
                        st_d[i] = GW_PEND;
                    end
                end
                GW_PEND: begin
                    if (grant[i]) begin
                        st_d[i] = GW_SERV;
                    end
                    if (rise[i] && cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                GW_SERV: begin
                    if (comp_ok[i]) begin
                        if (!tm_i[i]) begin
                            st_d[i] = sync2_q[i] ? GW_PEND : GW_IDLE;
                        end else if (cnt_q[i] != '0) begin
                            // A same-cycle edge replaces the one consumed.
                            st_d[i] = GW_PEND;
                            if (!rise[i]) begin
                                cnt_d[i] = cnt_q[i] - 1'b1;
                            end
                        end else if (rise[i]) begin
                            st_d[i] = GW_PEND;
                        end else begin
                            st_d[i] = GW_IDLE;
                        end
                    end else if (rise[i] && cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: st_d[i] = GW_IDLE;
            endcase
            if (!tm_i[i]) begin
                cnt_d[i] = '0;
            end
            pend_d[i] = (st_d[i] == GW_PEND);
        end
        st_d[0]   = GW_IDLE;
        cnt_d[0]  = '0;
        pend_d[0] = 1'b0;
    end

    // Strict compare keeps the lowest id among equal priorities.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        id_d      = '0;
        for (int c = 0; c < CTX_NUM; c++) begin
            for (int i = 0; i < IRQ_NUM; i++) begin
                if (pend_d[i] && ie[c][i] && prio[i] > best_prio[c]) begin
                    best_id[c]   = ID_W'(i);
                    best_prio[c] = prio[i];
                end
            end
            id_d[c] = (best_prio[c] > thold[c]) ? best_id[c] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            cnt_q   <= '0;
            ip_q    <= '0;
            id_q    <= '0;
            irq_q   <= '0;
            for (int i = 0; i < IRQ_NUM; i++) begin
                st_q[i] <= GW_IDLE;
            end
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            cnt_q   <= cnt_d;
            ip_q    <= pend_d;
            id_q    <= id_d;
            for (int c = 0; c < CTX_NUM; c++) begin
                irq_q[c] <= |id_d[c];
            end
            for (int i = 0; i < IRQ_NUM; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

    assign ip_o       = ip_q;
    assign id_o       = id_q;
    assign irq_o      = irq_q;
    assign claim_id_o = claim_id;

endmodule

// File: tb/tb_plic_mctx_core.sv
// Bench for plic_mctx_core: table vectors, directed corner sequences and
// a randomized run checked against a cycle-level behavioural model.
module tb_plic_mctx_core;

    localparam int N  = 32;
    localparam int C  = 2;
    localparam int P  = 3;
    localparam int IW = 5;
    localparam int CMAX = 7;
    localparam int S_IDLE = 0;
    localparam int S_PEND = 1;
    localparam int S_SERV = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   irq, tm;
    logic [N*P-1:0] prio;
    logic [C*N-1:0] ie;
    logic [C*P-1:0] thold;
    logic [C-1:0]   claim, comp;
    logic [C*IW-1:0] comp_id;
    logic [N-1:0]   ip;
    logic [C*IW-1:0] id, claim_id;
    logic [C-1:0]   irqo;

    int n_err = 0;
    int n_chk = 0;

    bit [N-1:0] m_s1, m_s2, m_s3, m_ip;
    int m_st [N];
    int m_cnt [N];
    int m_id [C];
    bit [C-1:0] m_irq;

    always #5 clk = ~clk;

    plic_mctx_core #(
        .IRQ_NUM(N), .CTX_NUM(C), .PRIO_WIDTH(P), .EDGE_CNT_W(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .irq_i(irq), .tm_i(tm),
        .prio_i(prio), .ie_i(ie), .thold_i(thold),
        .claim_i(claim), .comp_i(comp), .comp_id_i(comp_id),
        .ip_o(ip), .id_o(id), .claim_id_o(claim_id), .irq_o(irqo)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int prio_of(int i);
        return int'(prio[i*P +: P]);
    endfunction

    function automatic int exp_claim(int c);
        if (rst || m_id[c] == 0) return 0;
        for (int d = 0; d < c; d++)
            if (claim[d] && m_id[d] == m_id[c]) return 0;
        return m_id[c];
    endfunction

    function automatic logic [C*IW-1:0] exp_cid_vec();
        logic [C*IW-1:0] r;
        for (int c = 0; c < C; c++) r[c*IW +: IW] = IW'(exp_claim(c));
        return r;
    endfunction

    function automatic logic [C*IW-1:0] m_id_vec();
        logic [C*IW-1:0] r;
        for (int c = 0; c < C; c++) r[c*IW +: IW] = IW'(m_id[c]);
        return r;
    endfunction

    function automatic int min7(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // One clock edge of the reference: sources as request/serve tokens.
    function automatic void model_step();
        bit [N-1:0] rs, gr, cp;
        int nst [N];
        int ncnt [N];
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_s3 = '0; m_ip = '0; m_irq = '0;
            for (int i = 0; i < N; i++) begin m_st[i] = S_IDLE; m_cnt[i] = 0; end
            for (int c = 0; c < C; c++) m_id[c] = 0;
            return;
        end
        rs = m_s2 & ~m_s3;
        gr = '0;
        cp = '0;
        for (int c = 0; c < C; c++) begin
            int g = claim[c] ? exp_claim(c) : 0;
            int k = int'(comp_id[c*IW +: IW]);
            if (g != 0) gr[g] = 1'b1;
            if (comp[c] && k > 0 && k < N && m_st[k] == S_SERV && ie[c*N+k])
                cp[k] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            int tot = m_cnt[i] + ((tm[i] && rs[i]) ? 1 : 0);
            nst[i] = m_st[i];
            ncnt[i] = m_cnt[i];
            if (i == 0) begin
                nst[i] = S_IDLE;
            end else if (m_st[i] == S_IDLE) begin
                if (tm[i] ? rs[i] : m_s2[i]) nst[i] = S_PEND;
            end else if (m_st[i] == S_PEND) begin
                ncnt[i] = min7(tot);
                if (gr[i]) nst[i] = S_SERV;
            end else if (!cp[i]) begin
                ncnt[i] = min7(tot);
            end else if (!tm[i]) begin
                nst[i] = m_s2[i] ? S_PEND : S_IDLE;
            end else if (tot > 0) begin
                nst[i] = S_PEND;
                ncnt[i] = min7(tot - 1);
            end else begin
                nst[i] = S_IDLE;
            end
            if (!tm[i] || i == 0) ncnt[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            m_st[i] = nst[i];
            m_cnt[i] = ncnt[i];
            m_ip[i] = (nst[i] == S_PEND);
        end
        for (int c = 0; c < C; c++) begin
            int win = 0;
            int wp = 0;
            for (int p = (1 << P) - 1; p >= 1 && win == 0; p--)
                for (int i = 1; i < N; i++)
                    if (win == 0 && m_ip[i] && ie[c*N+i] && prio_of(i) == p) begin
                        win = i;
                        wp = p;
                    end
            m_id[c] = (win != 0 && wp > int'(thold[c*P +: P])) ? win : 0;
            m_irq[c] = (m_id[c] != 0);
        end
        m_s3 = m_s2;
        m_s2 = m_s1;
        m_s1 = irq;
    endfunction

    task automatic cyc();
        #1;
        chk("claim_id", claim_id, exp_cid_vec());
        @(posedge clk);
        model_step();
        #1;
        chk("ip", ip, m_ip);
        chk("id", id, m_id_vec());
        chk("irq", irqo, m_irq);
        @(negedge clk);
        claim = '0;
        comp = '0;
    endtask

    task automatic clear_cfg();
        irq = '0; tm = '0; prio = '0; ie = '0; thold = '0;
        claim = '0; comp = '0; comp_id = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_claim(input int c);
        claim[c] = 1'b1;
        cyc();
    endtask

    task automatic do_comp(input int c, input int k);
        comp[c] = 1'b1;
        comp_id[c*IW +: IW] = IW'(k);
        cyc();
    endtask

    task automatic pulse(input int i);
        irq[i] = 1'b1;
        cyc();
        irq[i] = 1'b0;
        cyc();
    endtask

    task automatic wait_ip(input int i);
        int k = 0;
        while (!ip[i] && k < 10) begin
            cyc();
            k++;
        end
        chk("wait_ip", ip[i], 1);
    endtask

    function automatic int id_c(int c);
        return int'(id[c*IW +: IW]);
    endfunction

    typedef struct {
        bit irq5;
        bit clm;
        bit cmp;
        bit e_ip;
        int e_id;
        bit e_irq;
        int e_cid;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 5, 1, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0, 5};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 1, 5, 1, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 5};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0};

        clear_cfg();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_ip", ip, 0);
        chk("rst_id", id, 0);
        chk("rst_irq", irqo, 0);
        rst = 1'b0;

        // Level source 5, context 0.
        prio[5*P +: P] = 3'd3;
        ie[5] = 1'b1;
        for (int k = 0; k < 11; k++) begin
            irq[5] = tbl[k].irq5;
            claim[0] = tbl[k].clm;
            comp[0] = tbl[k].cmp;
            comp_id[0 +: IW] = 5'd5;
            #1;
            chk("tbl_cid", claim_id[0 +: IW], tbl[k].e_cid);
            cyc();
            chk("tbl_ip5", ip[5], tbl[k].e_ip);
            chk("tbl_id", id_c(0), tbl[k].e_id);
            chk("tbl_irq", irqo[0], tbl[k].e_irq);
        end

        // Priority, tie and threshold.
        clear_cfg();
        do_reset();
        prio[3*P +: P] = 3'd4;
        prio[7*P +: P] = 3'd4;
        prio[9*P +: P] = 3'd6;
        ie[3] = 1'b1; ie[7] = 1'b1; ie[9] = 1'b1;
        irq[3] = 1'b1; irq[7] = 1'b1; irq[9] = 1'b1;
        wait_ip(9);
        chk("prio_best", id_c(0), 9);
        thold[0 +: P] = 3'd6;
        cyc();
        chk("thold_id", id_c(0), 0);
        chk("thold_irq", irqo[0], 0);
        thold[0 +: P] = 3'd3;
        cyc();
        chk("thold3_id", id_c(0), 9);
        do_claim(0);
        chk("tie_low", id_c(0), 3);
        do_comp(0, 9);
        chk("repend9", id_c(0), 9);

        // Edge counting and saturation on source 4.
        clear_cfg();
        do_reset();
        tm[4] = 1'b1;
        prio[4*P +: P] = 3'd2;
        ie[4] = 1'b1;
        pulse(4);
        wait_ip(4);
        do_claim(0);
        chk("edge_serv", ip[4], 0);
        for (int k = 0; k < 10; k++) pulse(4);
        cyc();
        cyc();
        for (int r = 0; r < 8; r++) begin
            do_comp(0, 4);
            chk("edge_round", ip[4], (r < 7) ? 1 : 0);
            if (r < 7) do_claim(0);
        end
        pulse(4);
        wait_ip(4);
        do_claim(0);
        irq[4] = 1'b1;
        cyc();
        cyc();
        do_comp(0, 4);
        irq[4] = 1'b0;
        chk("same_cyc_pend", ip[4], 1);
        do_claim(0);
        cyc();
        do_comp(0, 4);
        chk("cnt0_idle", ip[4], 0);

        // Two contexts race on source 6.
        clear_cfg();
        do_reset();
        prio[6*P +: P] = 3'd5;
        ie[6] = 1'b1;
        ie[N+6] = 1'b1;
        irq[6] = 1'b1;
        wait_ip(6);
        claim = 2'b11;
        #1;
        chk("race_c0", claim_id[0 +: IW], 6);
        chk("race_c1", claim_id[IW +: IW], 0);
        cyc();
        chk("race_serv", ip[6], 0);
        do_comp(1, 6);
        chk("comp_c1", ip[6], 1);

        // Ignored completes and empty claims.
        do_claim(0);
        prio[8*P +: P] = 3'd1;
        ie[8] = 1'b1;
        irq[8] = 1'b1;
        wait_ip(8);
        do_comp(0, 0);
        chk("comp_id0", ip[6], 0);
        do_comp(0, 8);
        chk("comp_pend", ip[8], 1);
        ie[N+6] = 1'b0;
        cyc();
        do_comp(1, 6);
        chk("comp_noie", ip[6], 0);
        do_claim(1);
        chk("claim_none", ip[8], 1);

        // Reset while serving with a non-zero count.
        clear_cfg();
        do_reset();
        tm[2] = 1'b1;
        prio[2*P +: P] = 3'd7;
        ie[2] = 1'b1;
        pulse(2);
        wait_ip(2);
        do_claim(0);
        for (int k = 0; k < 3; k++) pulse(2);
        cyc();
        cyc();
        rst = 1'b1;
        do_comp(0, 2);
        rst = 1'b0;
        chk("mrst_ip", ip, 0);
        chk("mrst_id", id, 0);
        chk("mrst_irq", irqo, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("mrst_quiet", ip, 0);
        end

        // Randomized traffic.
        clear_cfg();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                prio = {$urandom, $urandom, $urandom};
                ie = {$urandom, $urandom};
                tm = $urandom;
                thold = P'($urandom_range(0, 3)) | (P'($urandom_range(0, 3)) << P);
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            claim = C'($urandom_range(0, 3));
            for (int c = 0; c < C; c++) begin
                int k = $urandom_range(0, N - 1);
                bit hit = 1'b0;
                comp[c] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 3) != 0)
                    for (int j = 0; j < N; j++)
                        if (!hit && m_st[(k + j) % N] == S_SERV) begin
                            k = (k + j) % N;
                            hit = 1'b1;
                        end
                comp_id[c*IW +: IW] = IW'(k);
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc();
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
